// File: rtl/sd_bd_pkg.sv
// sd_bd_pkg: shared constants for the buffer-descriptor store.
//   RAM_MEM_WIDTH - descriptor word width
//   BD_SIZE       - RAM depth in words (power of 2)
//   BD_WIDTH      - width of the free-slot counter
//   BD_EMPTY      - descriptor slot count (free_bd value when empty)
//   READ_CYCLE    - words per descriptor (sys_adr, cmd_arg)
//   BD_PTR_W      - RAM pointer width
package sd_bd_pkg;
  localparam int unsigned RAM_MEM_WIDTH = 32;
  localparam int unsigned BD_SIZE       = 16;
  localparam int unsigned BD_WIDTH      = 4;
  localparam int unsigned BD_EMPTY      = BD_SIZE / 2;
  localparam int unsigned READ_CYCLE    = 2;
  localparam int unsigned BD_PTR_W      = $clog2(BD_SIZE);
endpackage

// File: rtl/sd_bd_ram.sv
// sd_bd_ram: 1-write/1-read register array holding descriptor words.
//   clk    - system clock
//   we     - write strobe
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational; the read register lives in the caller)
// Contents are intentionally not reset.
module sd_bd_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sd_bd_fifo.sv
// sd_bd_fifo: buffer-descriptor store, responder end of the data master's
// descriptor-read handshake. The host writes 2-word descriptors
// (sys_adr, cmd_arg) into a circular RAM; the master reads them word by word
// with re_s/ack_o_s and frees a descriptor with a rising edge on a_cmp.
//   clk, rst   - clock, asynchronous active-high reset
//   we_m       - host write strobe (one word per cycle)
//   dat_in_m   - host write data
//   bd_clr     - synchronous flush of pointers and counters
//   re_s       - read request from the data master
//   ack_o_s    - one-cycle read acknowledge
//   dat_out_s  - read data, valid while ack_o_s is high
//   a_cmp      - descriptor complete (level; edge-detected here)
//   free_bd    - free descriptor slots (BD_EMPTY when empty)
//   wr_err     - one-cycle pulse after a dropped host write
module sd_bd_fifo
  import sd_bd_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_m,
  input  logic [RAM_MEM_WIDTH-1:0] dat_in_m,
  input  logic                     bd_clr,
  input  logic                     re_s,
  output logic                     ack_o_s,
  output logic [RAM_MEM_WIDTH-1:0] dat_out_s,
  input  logic                     a_cmp,
  output logic [BD_WIDTH-1:0]      free_bd,
  output logic                     wr_err
);

  localparam int unsigned AVAIL_W = BD_PTR_W + 1;

  logic [BD_PTR_W-1:0]      wr_ptr;
  logic [BD_PTR_W-1:0]      rd_ptr;
  logic                     wr_phase;
  logic [AVAIL_W-1:0]       avail_w;
  logic                     a_cmp_q;
  logic [RAM_MEM_WIDTH-1:0] ram_rdata;

  logic full;
  logic wr_ok;
  logic commit;
  logic rd_go;
  logic free_inc;
  logic ram_we;

  // Decisions use the pre-edge free_bd, so a same-cycle free cannot rescue
  // a write against a full store.
  assign full     = (free_bd == '0);
  assign wr_ok    = we_m & ~full;
  assign commit   = wr_ok & wr_phase;
  // avail_w counts committed words only, so a half-written descriptor is
  // never readable and reads can't collide with the word being written.
  assign rd_go    = re_s & ~ack_o_s & (avail_w != '0);
  assign free_inc = a_cmp & ~a_cmp_q & (free_bd != BD_WIDTH'(BD_EMPTY));
  assign ram_we   = wr_ok & ~bd_clr;

  sd_bd_ram #(
    .WIDTH (RAM_MEM_WIDTH),
    .DEPTH (BD_SIZE),
    .AW    (BD_PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (dat_in_m),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_o_s   <= 1'b0;
      dat_out_s <= '0;
      wr_err    <= 1'b0;
      free_bd   <= BD_WIDTH'(BD_EMPTY);
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_phase  <= 1'b0;
      avail_w   <= '0;
      a_cmp_q   <= 1'b0;
    end else if (bd_clr) begin
      ack_o_s   <= 1'b0;
      dat_out_s <= '0;
      wr_err    <= 1'b0;
      free_bd   <= BD_WIDTH'(BD_EMPTY);
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_phase  <= 1'b0;
      avail_w   <= '0;
      a_cmp_q   <= 1'b0;
    end else begin
      a_cmp_q <= a_cmp;
      ack_o_s <= rd_go;
      wr_err  <= we_m & full;

      if (wr_ok) begin
        wr_ptr   <= wr_ptr + BD_PTR_W'(1);
        wr_phase <= ~wr_phase;
      end

      if (rd_go) begin
        rd_ptr    <= rd_ptr + BD_PTR_W'(1);
        dat_out_s <= ram_rdata;
      end

      // Commit and free in the same cycle cancel out.
      case ({commit, free_inc})
        2'b10:   free_bd <= free_bd - BD_WIDTH'(1);
        2'b01:   free_bd <= free_bd + BD_WIDTH'(1);
        default: free_bd <= free_bd;
      endcase

      avail_w <= avail_w + (commit ? AVAIL_W'(READ_CYCLE) : AVAIL_W'(0))
                         - AVAIL_W'(rd_go);
    end
  end

endmodule

// File: tb/tb_sd_bd_fifo.sv
module tb_sd_bd_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_m;
  logic [31:0] dat_in_m;
  logic        bd_clr;
  logic        re_s;
  logic        ack_o_s;
  logic [31:0] dat_out_s;
  logic        a_cmp;
  logic [3:0]  free_bd;
  logic        wr_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sd_bd_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .we_m      (we_m),
    .dat_in_m  (dat_in_m),
    .bd_clr    (bd_clr),
    .re_s      (re_s),
    .ack_o_s   (ack_o_s),
    .dat_out_s (dat_out_s),
    .a_cmp     (a_cmp),
    .free_bd   (free_bd),
    .wr_err    (wr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] d);
    we_m     = 1'b1;
    dat_in_m = d;
    tick();
    we_m     = 1'b0;
  endtask

  task automatic clr();
    bd_clr = 1'b1;
    tick();
    bd_clr = 1'b0;
  endtask

  task automatic read_desc(input int cycles, output logic [31:0] d0,
                           output logic [31:0] d1, output int nack,
                           output logic [7:0] pattern);
    d0 = '0; d1 = '0; nack = 0; pattern = '0;
    re_s = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      pattern[i] = ack_o_s;
      if (ack_o_s) begin
        if (nack == 0) d0 = dat_out_s;
        else d1 = dat_out_s;
        nack++;
      end
    end
    re_s = 1'b0;
  endtask

  task automatic pulse_acmp();
    a_cmp = 1'b1;
    tick();
    a_cmp = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({ack_o_s, wr_err, dat_out_s, free_bd} !== {1'b0, 1'b0, 32'h0, 4'd8}) begin
      errors++;
      $display("FAIL reset_state: ack=%b wr_err=%b dat=%h free=%0d, want 0 0 0 8",
               ack_o_s, wr_err, dat_out_s, free_bd);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dut.avail_w !== 5'd0 || dut.wr_ptr !== 4'd0) begin
      errors++;
      $display("FAIL reset_ptrs: avail=%0d wr_ptr=%0d, want 0 0", dut.avail_w, dut.wr_ptr);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d0, d1;
    logic [7:0]  pat;
    int          n;
    write_word(32'h1000_0000);
    checks++;
    if (free_bd !== 4'd8) begin
      errors++;
      $display("FAIL basic_half_free: free=%0d want 8", free_bd);
    end
    write_word(32'h0000_0040);
    checks++;
    if (free_bd !== 4'd7) begin
      errors++;
      $display("FAIL basic_commit_free: free=%0d want 7", free_bd);
    end
    read_desc(6, d0, d1, n, pat);
    checks++;
    if (pat !== 8'b0000_0101 || n != 2) begin
      errors++;
      $display("FAIL basic_ack_pattern: pattern=%b n=%0d want 00000101 2", pat, n);
    end
    checks++;
    if (d0 !== 32'h1000_0000 || d1 !== 32'h0000_0040) begin
      errors++;
      $display("FAIL basic_data: d0=%h d1=%h want 10000000 00000040", d0, d1);
    end
    pulse_acmp();
    checks++;
    if (free_bd !== 4'd8) begin
      errors++;
      $display("FAIL basic_free: free=%0d want 8", free_bd);
    end
  endtask

  task automatic test_half_written();
    int n = 0;
    write_word(32'hAAAA_0001);
    re_s = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack_o_s) n++;
    end
    checks++;
    if (n != 0 || free_bd !== 4'd8) begin
      errors++;
      $display("FAIL half_no_ack: acks=%0d free=%0d want 0 8", n, free_bd);
    end
    write_word(32'hBBBB_0002);
    checks++;
    if (ack_o_s !== 1'b0) begin
      errors++;
      $display("FAIL half_commit_ack: ack=%b want 0", ack_o_s);
    end
    tick();
    checks++;
    if (ack_o_s !== 1'b1 || dat_out_s !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL half_word0: ack=%b dat=%h want 1 aaaa0001", ack_o_s, dat_out_s);
    end
    tick();
    tick();
    checks++;
    if (ack_o_s !== 1'b1 || dat_out_s !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL half_word1: ack=%b dat=%h want 1 bbbb0002", ack_o_s, dat_out_s);
    end
    re_s = 1'b0;
    tick();
    pulse_acmp();
  endtask

  task automatic test_full();
    logic [31:0] d0, d1;
    logic [7:0]  pat;
    int          n;
    clr();
    for (int i = 0; i < 16; i++) write_word(32'h3000_0000 + 32'(i));
    checks++;
    if (free_bd !== 4'd0 || dut.wr_ptr !== 4'd0) begin
      errors++;
      $display("FAIL full_count: free=%0d wr_ptr=%0d want 0 0", free_bd, dut.wr_ptr);
    end
    write_word(32'hDEAD_BEEF);
    checks++;
    if (wr_err !== 1'b1 || dut.wr_ptr !== 4'd0 || free_bd !== 4'd0) begin
      errors++;
      $display("FAIL full_reject: wr_err=%b wr_ptr=%0d free=%0d want 1 0 0",
               wr_err, dut.wr_ptr, free_bd);
    end
    tick();
    checks++;
    if (wr_err !== 1'b0) begin
      errors++;
      $display("FAIL full_err_pulse: wr_err=%b want 0", wr_err);
    end
    pulse_acmp();
    checks++;
    if (free_bd !== 4'd1) begin
      errors++;
      $display("FAIL full_free_one: free=%0d want 1", free_bd);
    end
    read_desc(4, d0, d1, n, pat);
    checks++;
    if (n != 2 || d0 !== 32'h3000_0000 || d1 !== 32'h3000_0001) begin
      errors++;
      $display("FAIL full_ram_intact: n=%0d d0=%h d1=%h want 2 30000000 30000001", n, d0, d1);
    end
    write_word(32'hCAFE_0000);
    checks++;
    if (wr_err !== 1'b0 || dut.wr_ptr !== 4'd1) begin
      errors++;
      $display("FAIL full_wrap_write: wr_err=%b wr_ptr=%0d want 0 1", wr_err, dut.wr_ptr);
    end
  endtask

  task automatic test_acmp_level();
    clr();
    for (int i = 0; i < 4; i++) write_word(32'h4000_0000 + 32'(i));
    checks++;
    if (free_bd !== 4'd6) begin
      errors++;
      $display("FAIL acmp_setup: free=%0d want 6", free_bd);
    end
    a_cmp = 1'b1;
    repeat (3) tick();
    checks++;
    if (free_bd !== 4'd7) begin
      errors++;
      $display("FAIL acmp_level_once: free=%0d want 7", free_bd);
    end
    a_cmp = 1'b0;
    tick();
    pulse_acmp();
    pulse_acmp();
    checks++;
    if (free_bd !== 4'd8) begin
      errors++;
      $display("FAIL acmp_saturate: free=%0d want 8", free_bd);
    end
  endtask

  task automatic test_commit_and_free();
    clr();
    for (int i = 0; i < 7; i++) write_word(32'h5000_0000 + 32'(i));
    checks++;
    if (free_bd !== 4'd5) begin
      errors++;
      $display("FAIL simul_setup: free=%0d want 5", free_bd);
    end
    a_cmp = 1'b1;
    write_word(32'h5000_0007);
    a_cmp = 1'b0;
    checks++;
    if (free_bd !== 4'd5 || dut.avail_w !== 5'd8) begin
      errors++;
      $display("FAIL simul_commit_free: free=%0d avail=%0d want 5 8", free_bd, dut.avail_w);
    end
    tick();
  endtask

  task automatic test_clr_mid_read();
    logic [31:0] d0, d1;
    logic [7:0]  pat;
    int          n;
    clr();
    write_word(32'h1111_0000);
    write_word(32'h1111_0001);
    re_s = 1'b1;
    tick();
    checks++;
    if (ack_o_s !== 1'b1 || dat_out_s !== 32'h1111_0000) begin
      errors++;
      $display("FAIL clr_word0: ack=%b dat=%h want 1 11110000", ack_o_s, dat_out_s);
    end
    tick();
    bd_clr = 1'b1;
    tick();
    bd_clr = 1'b0;
    re_s   = 1'b0;
    checks++;
    if (ack_o_s !== 1'b0 || free_bd !== 4'd8 || dut.avail_w !== 5'd0) begin
      errors++;
      $display("FAIL clr_drop: ack=%b free=%0d avail=%0d want 0 8 0",
               ack_o_s, free_bd, dut.avail_w);
    end
    write_word(32'h2222_0000);
    write_word(32'h2222_0001);
    read_desc(4, d0, d1, n, pat);
    checks++;
    if (n != 2 || d0 !== 32'h2222_0000 || d1 !== 32'h2222_0001) begin
      errors++;
      $display("FAIL clr_new_desc: n=%0d d0=%h d1=%h want 2 22220000 22220001", n, d0, d1);
    end
  endtask

  task automatic test_async_reset();
    write_word(32'h6000_0000);
    write_word(32'h6000_0001);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (free_bd !== 4'd8 || dut.avail_w !== 5'd0 || dut.wr_ptr !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: free=%0d avail=%0d wr_ptr=%0d want 8 0 0",
               free_bd, dut.avail_w, dut.wr_ptr);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; we_m = 1'b0; dat_in_m = '0; bd_clr = 1'b0; re_s = 1'b0; a_cmp = 1'b0;
    test_reset();
    test_basic();
    test_half_written();
    test_full();
    test_acmp_level();
    test_commit_and_free();
    test_clr_mid_read();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
